muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_iter.sv | 55 +++++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring shift-subtract divide
// on unsigned magnitudes. acc holds {HI-part, LO-part} of the working value.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   a_in,
   input  logic [XLEN-1:0]   b_in,
   output logic [2*XLEN-1:0] acc
);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     trial;

   always_comb begin
      acc_d   = acc_q;
      b_d     = b_q;
      add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      // Partial remainder stays below the divisor, so the shifted value fits in XLEN+1 bits
      // and bit XLEN of the difference is a reliable borrow.
      trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
      if (load) begin
         acc_d = {{XLEN{1'b0}}, a_in};
         b_d   = b_in;
      end else if (step) begin
         if (is_div) begin
            if (!trial[XLEN]) acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else              acc_d = {acc_q[2*XLEN-2:0], 1'b0};
         end else begin
            acc_d = {add_sum, acc_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: IDLE -> RUN (XLEN iterations) -> FIX (sign fix, HI/LO write).
// MTHI/MTLO writes are accepted only while idle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            hi_we,
   input  logic            lo_we,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_e             op_q, op_d;
   logic            neg_a_q, neg_a_d;
   logic            neg_b_q, neg_b_d;
   logic            dz_q, dz_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic              is_signed_in;
   logic              in_neg_a, in_neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              load, step, is_div;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;

   assign is_signed_in = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
   assign in_neg_a     = is_signed_in & src_a[XLEN-1];
   assign in_neg_b     = is_signed_in & src_b[XLEN-1];
   assign mag_a        = in_neg_a ? (~src_a + 1'b1) : src_a;
   assign mag_b        = in_neg_b ? (~src_b + 1'b1) : src_b;

   assign load   = (state_q == ST_IDLE) && start;
   assign step   = (state_q == ST_RUN);
   assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .is_div (is_div),
      .a_in   (mag_a),
      .b_in   (mag_b),
      .acc    (acc)
   );

   always_comb begin
      prod = (neg_a_q ^ neg_b_q) ? (~acc + 1'b1) : acc;
      quo  = acc[XLEN-1:0];
      rem  = acc[2*XLEN-1:XLEN];
      if (neg_a_q ^ neg_b_q) quo = ~quo + 1'b1;
      if (neg_a_q)           rem = ~rem + 1'b1;
      // Remainder of a divide by zero is |a| re-signed, i.e. src_a itself.
      if (dz_q)              quo = '1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               op_d    = op_e'(op);
               neg_a_d = in_neg_a;
               neg_b_d = in_neg_b;
               dz_d    = (src_b == '0);
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            if (is_div) begin
               hi_d = rem;
               lo_d = quo;
            end else begin
               hi_d = prod[2*XLEN-1:XLEN];
               lo_d = prod[XLEN-1:0];
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MULT;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: issued operations push {HI,LO} and the expected done cycle;
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 1;

   logic            clk;
   logic            rst;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            hi_we;
   logic            lo_we;
   logic [XLEN-1:0] wdata;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   logic [2*XLEN-1:0] exp_q[$];
   int                cyc_q[$];
   int                cyc;
   int                n_cmp;
   int                n_bad;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks; issue() expects to be called at a negedge
   task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [2*XLEN-1:0] exp, input logic push);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         exp_q.push_back(exp);
         cyc_q.push_back(cyc + LAT);
      end
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done within 100 cycles, expected one");
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [2*XLEN-1:0] e;
      int                c;
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
         end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("result_hi", 64'(hi), 64'(e[2*XLEN-1:XLEN]));
            check("result_lo", 64'(lo), 64'(e[XLEN-1:0]));
            check("done_cycle", 64'(cyc), 64'(c));
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      src_a = '0;
      src_b = '0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);

      // MTHI / MTLO while idle
      hi_we = 1'b1;
      wdata = 32'hA5A5A5A5;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      check("mthi", 64'(hi), 64'hA5A5A5A5);
      @(negedge clk);
      lo_we = 1'b1;
      wdata = 32'h5A5A5A5A;
      @(posedge clk);
      #1;
      lo_we = 1'b0;
      check("mtlo", 64'(lo), 64'h5A5A5A5A);

      // MULT -3 x 5 with a simultaneous MTHI that the result later overwrites
      @(negedge clk);
      hi_we = 1'b1;
      wdata = 32'h11112222;
      issue(2'b00, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b1);
      hi_we = 1'b0;
      check("mthi_with_start", 64'(hi), 64'h11112222);
      check("busy_after_start", 64'(busy), 64'd1);
      repeat (10) @(posedge clk);
      #1;
      check("hi_hold_run", 64'(hi), 64'h11112222);
      check("lo_hold_run", 64'(lo), 64'h5A5A5A5A);
      wait_done();

      // back-to-back: each start lands in the previous done cycle
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
      wait_done();
      issue(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
      wait_done();
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1);
      wait_done();
      issue(2'b11, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 1'b1);
      wait_done();
      issue(2'b10, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1);
      wait_done();
      issue(2'b00, 32'd7, 32'hFFFFFFF7, 64'hFFFFFFFF_FFFFFFC1, 1'b1);
      wait_done();
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);

      // abort: MULT 7x9, ignored DIVU start + MTHI at iteration 5, reset at iteration 10
      issue(2'b00, 32'd7, 32'd9, 64'd0, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      op    = 2'b11;
      hi_we = 1'b1;
      wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      start = 1'b0;
      hi_we = 1'b0;
      check("busy_ignore_start", 64'(busy), 64'd1);
      check("hi_we_ignored", 64'(hi), 64'hFFFFFFFF);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      lo_we = 1'b1;
      wdata = 32'h1234;
      @(posedge clk);
      #1;
      lo_we = 1'b0;
      check("mtlo_after_reset", 64'(lo), 64'h1234);
      check("hi_after_reset", 64'(hi), 64'd0);

      // first start after reset is accepted
      @(negedge clk);
      issue(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
      wait_done();

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
      repeat (40) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
